axi4l_mst_bridge: RTL

//  AXI4-Lite master that turns the core's single-beat load/store request
//  (LSU side) into AXI4-Lite read or write transactions on the system bus.
//  It drives the slave ports of iram, dram and peripherals. One transaction
//  is outstanding at a time. Each transaction returns one response pulse

---
 rtl/axi4l_mst_bridge_pkg.sv | 16 +
 rtl/axi4l_mst_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi4l_mst_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axi4l_mst_bridge_pkg
//  Shared constants for the LSU-to-AXI4-Lite master bridge: bus widths and
//  the AXI response encodings.
// ---------------------------------------------------------------------------
package axi4l_mst_bridge_pkg;

    localparam int MEM_AW = 32;   // byte address width
    localparam int MEM_DW = 32;   // data bus width
    localparam int MEM_SW = MEM_DW / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4l_mst_bridge.sv
// ---------------------------------------------------------------------------
// axi4l_mst_bridge
//  Converts single-beat LSU load/store requests into AXI4-Lite transactions.
//  One transaction is outstanding at a time; each one ends with a one-cycle
//  rsp_valid pulse carrying read data (0 for writes) and an error flag.
//
//  Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_*              LSU request (valid/ready, we, addr, wdata, wstrb)
//   rsp_*              LSU response (valid pulse, rdata, err)
//   m_axi_aw*/w*/b*    AXI4-Lite write address / data / response channels
//   m_axi_ar*/r*       AXI4-Lite read address / data channels
// ---------------------------------------------------------------------------
module axi4l_mst_bridge
    import axi4l_mst_bridge_pkg::*;
#(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    // LSU request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [MEM_AW-1:0] req_addr,
    input  logic [MEM_DW-1:0] req_wdata,
    input  logic [MEM_SW-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [MEM_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    // AXI4-Lite write
    output logic [MEM_AW-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [MEM_DW-1:0] m_axi_wdata,
    output logic [MEM_SW-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    // AXI4-Lite read
    output logic [MEM_AW-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [MEM_DW-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_aw_done, r_w_done;
    logic              r_awvalid, r_wvalid, r_arvalid;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_DW-1:0] r_wdata;
    logic [MEM_SW-1:0] r_wstrb;
    logic              r_rsp_valid, r_rsp_err;
    logic [MEM_DW-1:0] r_rsp_rdata;

    logic w_accept, w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_aw_hs  = r_awvalid && m_axi_awready;
    assign w_w_hs   = r_wvalid  && m_axi_wready;
    // A channel counts as finished if it completed earlier or completes now.
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done  || w_w_hs;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = req_we ? ST_WR_AW_W : ST_RD_AR;
            ST_WR_AW_W: if (w_aw_fin && w_w_fin) w_state_nxt = ST_WR_B;
            // B is only looked at here, so a slave holding bvalid high early
            // cannot finish the write before AW and W have both handshaken.
            ST_WR_B:    if (m_axi_bvalid) w_state_nxt = ST_IDLE;
            ST_RD_AR:   if (m_axi_arready) w_state_nxt = ST_RD_R;
            ST_RD_R:    if (m_axi_rvalid) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- registered AXI / response outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Payload only changes here, so it is stable for the
                    // whole time any valid is asserted.
                    if (w_accept) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (req_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                end
                ST_WR_B: begin
                    if (m_axi_bvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (m_axi_bresp != AXI_RESP_OKAY);
                        r_rsp_rdata <= '0;
                    end
                end
                ST_RD_AR: begin
                    if (m_axi_arready) r_arvalid <= 1'b0;
                end
                ST_RD_R: begin
                    if (m_axi_rvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (m_axi_rresp != AXI_RESP_OKAY);
                        r_rsp_rdata <= m_axi_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign m_axi_bready  = (r_state == ST_WR_B);
    assign m_axi_rready  = (r_state == ST_RD_R);

    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;

    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;

endmodule
